// File: rtl/modelbuf_read_arbiter_if.sv
// ----------------------------------------------------------------------------
// modelbuf_read_arbiter_pkg / modelbuf_read_arbiter_if
//
// Purpose:
//   Shared data types for the model-buffer read path, and the bundle of
//   handshake/bus signals between the scene-reader lanes, the read arbiter
//   and the model buffer.
//
// Modports:
//   slave  - the arbiter's view: takes lane requests and memory responses,
//            drives the memory request, lane grants/responses and status.
//   master - the environment's view (scene readers plus model buffer).
//
// Signals (lane side):
//   req_valid/req_ready/req_data        per-lane read request handshake
//   resp_valid/resp_ready               per-lane response handshake
//   resp_data/resp_metadata             response payload, broadcast to lanes
// Signals (memory side):
//   mem_req_valid/mem_req_ready/mem_req_data
//   mem_resp_valid/mem_resp_ready/mem_resp_data/mem_resp_metadata
// Status:
//   inflight    number of issued reads awaiting a response
//   orphan_err  sticky: a response arrived with nothing outstanding
// ----------------------------------------------------------------------------
package modelbuf_read_arbiter_pkg;

    typedef struct packed {
        logic [7:0]  model_index;
        logic [15:0] triangle_index;
    } modelbuf_read_t;

    typedef struct packed {
        logic [15:0] v0;
        logic [15:0] v1;
        logic [15:0] v2;
    } triangle_t;

    typedef struct packed {
        logic last;
    } triangle_meta_t;

endpackage

interface modelbuf_read_arbiter_if
    import modelbuf_read_arbiter_pkg::*;
#(
    parameter int NUM_REQ      = 2,
    parameter int MAX_INFLIGHT = 4
);
    localparam int CNT_W = $clog2(MAX_INFLIGHT) + 1;

    // Lane side
    logic           [NUM_REQ-1:0] req_valid;
    logic           [NUM_REQ-1:0] req_ready;
    modelbuf_read_t [NUM_REQ-1:0] req_data;
    logic           [NUM_REQ-1:0] resp_valid;
    logic           [NUM_REQ-1:0] resp_ready;
    triangle_t                    resp_data;
    triangle_meta_t               resp_metadata;

    // Model-buffer side
    logic                         mem_req_valid;
    logic                         mem_req_ready;
    modelbuf_read_t               mem_req_data;
    logic                         mem_resp_valid;
    logic                         mem_resp_ready;
    triangle_t                    mem_resp_data;
    triangle_meta_t               mem_resp_metadata;

    // Status
    logic           [CNT_W-1:0]   inflight;
    logic                         orphan_err;

    modport slave (
        input  req_valid, req_data, resp_ready,
               mem_req_ready, mem_resp_valid, mem_resp_data, mem_resp_metadata,
        output req_ready, resp_valid, resp_data, resp_metadata,
               mem_req_valid, mem_req_data, mem_resp_ready,
               inflight, orphan_err
    );

    modport master (
        output req_valid, req_data, resp_ready,
               mem_req_ready, mem_resp_valid, mem_resp_data, mem_resp_metadata,
        input  req_ready, resp_valid, resp_data, resp_metadata,
               mem_req_valid, mem_req_data, mem_resp_ready,
               inflight, orphan_err
    );

endinterface

// File: rtl/modelbuf_read_arbiter.sv
// ----------------------------------------------------------------------------
// modelbuf_read_arbiter
//
// Purpose:
//   Shares the single model-buffer read port between NUM_REQ scene-reader
//   lanes. Requests are granted round-robin and forwarded with zero latency;
//   the requester ID of every issued read is queued in an in-order tag FIFO
//   so each returned triangle is routed back to the lane that asked for it.
//   Responses are delivered strictly in issue order, so a stalled lane
//   blocks all responses behind it.
//
// Ports:
//   clk   clock
//   rstn  asynchronous active-low reset
//   bus   modelbuf_read_arbiter_if.slave (lane and model-buffer handshakes,
//         inflight count, sticky orphan_err)
// ----------------------------------------------------------------------------
module modelbuf_read_arbiter
    import modelbuf_read_arbiter_pkg::*;
#(
    parameter int NUM_REQ      = 2,
    parameter int MAX_INFLIGHT = 4,
    parameter int RIDX_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          rstn,
    modelbuf_read_arbiter_if.slave        bus
);

    localparam int                PTR_W     = $clog2(MAX_INFLIGHT);
    localparam int                CNT_W     = PTR_W + 1;
    localparam logic [RIDX_W-1:0] LAST_LANE = RIDX_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(MAX_INFLIGHT);

    // Registered state
    logic [RIDX_W-1:0] r_rr_ptr;
    logic [RIDX_W-1:0] r_tag_mem [MAX_INFLIGHT];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_orphan_err;

    // Combinational
    logic [RIDX_W-1:0] w_grant;
    logic [RIDX_W-1:0] w_head;
    logic              w_any_req;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;

    assign w_any_req = |bus.req_valid;
    assign w_full    = (r_count == FULL_CNT);
    assign w_empty   = (r_count == '0);
    assign w_head    = r_tag_mem[r_rd_ptr];

    // Round-robin scan: first valid lane at or after r_rr_ptr, wrapping.
    // With no lane valid the grant idles at r_rr_ptr; nothing is issued then.
    always_comb begin
        int  idx;
        logic found;
        // NOTE: every signal written here gets a default before any branch,
        // otherwise the tool infers a latch to hold the old value.
        w_grant = r_rr_ptr;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(r_rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && bus.req_valid[idx]) begin
                found   = 1'b1;
                w_grant = RIDX_W'(idx);
            end
        end
    end

    // Request path. mem_req_valid deliberately ignores mem_req_ready so the
    // model buffer may wait for valid before raising ready.
    assign bus.mem_req_valid = w_any_req && !w_full;
    assign w_push            = bus.mem_req_valid && bus.mem_req_ready;

    always_comb begin
        bus.mem_req_data = bus.req_data[0];
        bus.req_ready    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant == RIDX_W'(i)) begin
                bus.mem_req_data = bus.req_data[i];
                bus.req_ready[i] = w_any_req && bus.mem_req_ready && !w_full;
            end
        end
    end

    // Response path: only the lane recorded at the FIFO head sees valid, and
    // only its ready can accept. An empty FIFO means the response is an
    // orphan; it is never accepted nor routed.
    always_comb begin
        bus.resp_valid     = '0;
        bus.mem_resp_ready = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_head == RIDX_W'(i)) begin
                bus.resp_valid[i]  = bus.mem_resp_valid && !w_empty;
                bus.mem_resp_ready = !w_empty && bus.resp_ready[i];
            end
        end
    end

    assign w_pop = bus.mem_resp_valid && bus.mem_resp_ready;

    assign bus.resp_data     = bus.mem_resp_data;
    assign bus.resp_metadata = bus.mem_resp_metadata;
    assign bus.inflight      = r_count;
    assign bus.orphan_err    = r_orphan_err;

    // Tag storage. NOTE: the array has no reset; an entry is only read after
    // it was written, because w_empty masks the head while count is zero.
    always_ff @(posedge clk) begin
        if (w_push) r_tag_mem[r_wr_ptr] <= w_grant;
    end

    // Control state. NOTE: sequential state uses non-blocking assignments
    // so every register samples values from before the edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rr_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_orphan_err <= 1'b0;
        end else begin
            if (w_push) begin
                r_rr_ptr <= (w_grant == LAST_LANE) ? '0 : w_grant + 1'b1;
                r_wr_ptr <= r_wr_ptr + 1'b1;  // power-of-two depth: wraps
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (bus.mem_resp_valid && w_empty) begin
                r_orphan_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_modelbuf_read_arbiter.sv
// ----------------------------------------------------------------------------
// tb_modelbuf_read_arbiter
//
// Directed bench for modelbuf_read_arbiter with NUM_REQ=2, MAX_INFLIGHT=4.
// Inputs change 1 ns after the rising edge, outputs are compared 1 ns later.
// ----------------------------------------------------------------------------
module tb_modelbuf_read_arbiter;
    import modelbuf_read_arbiter_pkg::*;

    localparam int NUM_REQ      = 2;
    localparam int MAX_INFLIGHT = 4;

    logic clk = 1'b0;
    logic rstn;
    int   n_vec = 0;
    int   n_err = 0;
    int   grants0;
    int   grants1;

    modelbuf_read_arbiter_if #(.NUM_REQ(NUM_REQ), .MAX_INFLIGHT(MAX_INFLIGHT)) bus ();

    modelbuf_read_arbiter #(.NUM_REQ(NUM_REQ), .MAX_INFLIGHT(MAX_INFLIGHT)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic modelbuf_read_t mk_rd(input int m, input int t);
        modelbuf_read_t r;
        r.model_index    = 8'(m);
        r.triangle_index = 16'(t);
        return r;
    endfunction

    function automatic triangle_t mk_tri(input int k);
        triangle_t t;
        t.v0 = 16'(k * 3);
        t.v1 = 16'(k * 3 + 1);
        t.v2 = 16'(k * 3 + 2);
        return t;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        bus.req_valid         = '0;
        bus.req_data          = '0;
        bus.resp_ready        = '0;
        bus.mem_req_ready     = 1'b0;
        bus.mem_resp_valid    = 1'b0;
        bus.mem_resp_data     = '0;
        bus.mem_resp_metadata = '0;
    endtask

    task automatic drive_resp(input logic v, input int k, input logic last);
        bus.mem_resp_valid         = v;
        bus.mem_resp_data          = mk_tri(k);
        bus.mem_resp_metadata.last = last;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".mem_req_valid"},  64'(bus.mem_req_valid),  64'd0);
        check({tag, ".req_ready"},      64'(bus.req_ready),      64'd0);
        check({tag, ".resp_valid"},     64'(bus.resp_valid),     64'd0);
        check({tag, ".mem_resp_ready"}, 64'(bus.mem_resp_ready), 64'd0);
        check({tag, ".inflight"},       64'(bus.inflight),       64'd0);
        check({tag, ".orphan_err"},     64'(bus.orphan_err),     64'd0);
    endtask

    // Reset asserted asynchronously between edges, held one cycle.
    task automatic do_reset(input string tag);
        idle_inputs();
        rstn = 1'b0;
        settle();
        check_all_zero(tag);
        next_cycle();
        rstn = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] exp_rdy;
        logic [1:0] exp_rv;

        // ---------------- power-on reset ----------------
        idle_inputs();
        rstn = 1'b0;
        #2;
        check_all_zero("por");
        next_cycle();
        next_cycle();
        rstn = 1'b1;
        settle();
        check_all_zero("idle");

        // mem_req_valid must not wait for mem_req_ready
        bus.req_valid   = 2'b01;
        bus.req_data[0] = mk_rd(3, 0);
        bus.resp_ready  = 2'b11;
        settle();
        check("stall.mem_req_valid", 64'(bus.mem_req_valid), 64'd1);
        check("stall.req_ready",     64'(bus.req_ready),     64'd0);
        next_cycle();
        check("stall.inflight",      64'(bus.inflight),      64'd0);

        // ---------------- single lane ----------------
        bus.mem_req_ready = 1'b1;
        settle();
        check("s1.issue0.data",  64'(bus.mem_req_data), 64'(mk_rd(3, 0)));
        check("s1.issue0.ready", 64'(bus.req_ready),    64'd1);
        next_cycle();
        for (int k = 1; k <= 3; k++) begin
            if (k < 3) bus.req_data[0] = mk_rd(3, k);
            else       bus.req_valid   = 2'b00;
            drive_resp(1'b1, k - 1, (k == 3));
            settle();
            if (k < 3) check("s1.issue.data", 64'(bus.mem_req_data), 64'(mk_rd(3, k)));
            else       check("s1.no_issue",   64'(bus.mem_req_valid), 64'd0);
            check("s1.resp_valid",     64'(bus.resp_valid),         64'd1);
            check("s1.mem_resp_ready", 64'(bus.mem_resp_ready),     64'd1);
            check("s1.resp_data",      64'(bus.resp_data),          64'(mk_tri(k - 1)));
            check("s1.resp_last",      64'(bus.resp_metadata.last), 64'((k == 3) ? 1 : 0));
            check("s1.inflight",       64'(bus.inflight),           64'd1);
            next_cycle();
        end
        drive_resp(1'b0, 0, 1'b0);
        settle();
        check("s1.end.inflight",   64'(bus.inflight),   64'd0);
        check("s1.end.resp_valid", 64'(bus.resp_valid), 64'd0);

        // ---------------- round-robin fairness ----------------
        do_reset("rst_rr");
        bus.req_valid     = 2'b11;
        bus.req_data[0]   = mk_rd(0, 16);
        bus.req_data[1]   = mk_rd(1, 32);
        bus.mem_req_ready = 1'b1;
        bus.resp_ready    = 2'b11;
        grants0 = 0;
        grants1 = 0;
        for (int k = 0; k < 8; k++) begin
            drive_resp(k > 0, k, 1'b0);
            settle();
            exp_rdy = (k % 2 == 0) ? 2'b01 : 2'b10;
            exp_rv  = (k == 0) ? 2'b00 : ((k % 2 == 0) ? 2'b10 : 2'b01);
            check("rr.req_ready",  64'(bus.req_ready),  64'(exp_rdy));
            check("rr.mem_data",   64'(bus.mem_req_data),
                  (k % 2 == 0) ? 64'(mk_rd(0, 16)) : 64'(mk_rd(1, 32)));
            check("rr.resp_valid", 64'(bus.resp_valid), 64'(exp_rv));
            if (bus.req_ready[0]) grants0++;
            if (bus.req_ready[1]) grants1++;
            next_cycle();
        end
        bus.req_valid = 2'b00;
        drive_resp(1'b1, 8, 1'b0);
        settle();
        check("rr.drain.resp_valid", 64'(bus.resp_valid), 64'd2);
        next_cycle();
        drive_resp(1'b0, 0, 1'b0);
        settle();
        check("rr.inflight", 64'(bus.inflight), 64'd0);
        check("rr.grants0",  64'(grants0),      64'd4);
        check("rr.grants1",  64'(grants1),      64'd4);

        // ---------------- full FIFO ----------------
        bus.req_valid = 2'b11;
        for (int c = 0; c < 6; c++) begin
            settle();
            exp_rdy = (c >= 4) ? 2'b00 : ((c % 2 == 0) ? 2'b01 : 2'b10);
            check("full.mem_req_valid", 64'(bus.mem_req_valid), 64'((c < 4) ? 1 : 0));
            check("full.req_ready",     64'(bus.req_ready),     64'(exp_rdy));
            check("full.inflight",      64'(bus.inflight),      64'((c < 4) ? c : 4));
            next_cycle();
        end
        drive_resp(1'b1, 20, 1'b0);
        settle();
        check("full.pop.resp_valid",     64'(bus.resp_valid),     64'd1);
        check("full.pop.mem_resp_ready", 64'(bus.mem_resp_ready), 64'd1);
        check("full.pop.no_issue",       64'(bus.mem_req_valid),  64'd0);
        check("full.pop.req_ready",      64'(bus.req_ready),      64'd0);
        next_cycle();
        drive_resp(1'b0, 0, 1'b0);
        settle();
        check("full.refill.valid",    64'(bus.mem_req_valid), 64'd1);
        check("full.refill.ready",    64'(bus.req_ready),     64'd1);
        check("full.refill.inflight", 64'(bus.inflight),      64'd3);
        next_cycle();
        bus.req_valid = 2'b00;
        for (int d = 0; d < 4; d++) begin
            drive_resp(1'b1, 30 + d, 1'b0);
            settle();
            exp_rv = (d % 2 == 0) ? 2'b10 : 2'b01;
            check("full.drain.resp_valid", 64'(bus.resp_valid), 64'(exp_rv));
            next_cycle();
        end
        drive_resp(1'b0, 0, 1'b0);
        settle();
        check("full.drain.inflight", 64'(bus.inflight), 64'd0);

        // ---------------- routing and back-pressure ----------------
        for (int s = 0; s < 3; s++) begin
            exp_rdy = (s == 1) ? 2'b01 : 2'b10;
            bus.req_valid = exp_rdy;
            settle();
            check("route.issue", 64'(bus.req_ready), 64'(exp_rdy));
            next_cycle();
        end
        bus.req_valid = 2'b00;
        drive_resp(1'b1, 50, 1'b0);
        settle();
        check("route.r1.resp_valid", 64'(bus.resp_valid),     64'd2);
        check("route.r1.ready",      64'(bus.mem_resp_ready), 64'd1);
        next_cycle();
        bus.resp_ready = 2'b10;
        drive_resp(1'b1, 51, 1'b0);
        for (int h = 0; h < 3; h++) begin
            settle();
            check("route.hold.resp_valid", 64'(bus.resp_valid),     64'd1);
            check("route.hold.ready",      64'(bus.mem_resp_ready), 64'd0);
            check("route.hold.inflight",   64'(bus.inflight),       64'd2);
            next_cycle();
        end
        bus.resp_ready = 2'b11;
        settle();
        check("route.r2.resp_valid", 64'(bus.resp_valid),     64'd1);
        check("route.r2.ready",      64'(bus.mem_resp_ready), 64'd1);
        next_cycle();
        drive_resp(1'b1, 52, 1'b1);
        settle();
        check("route.r3.resp_valid", 64'(bus.resp_valid), 64'd2);
        check("route.r3.data",       64'(bus.resp_data),  64'(mk_tri(52)));
        next_cycle();
        drive_resp(1'b0, 0, 1'b0);
        settle();
        check("route.inflight", 64'(bus.inflight), 64'd0);

        // ---------------- orphan response ----------------
        drive_resp(1'b1, 60, 1'b1);
        settle();
        check("orphan.mem_resp_ready", 64'(bus.mem_resp_ready), 64'd0);
        check("orphan.resp_valid",     64'(bus.resp_valid),     64'd0);
        check("orphan.err_before",     64'(bus.orphan_err),     64'd0);
        next_cycle();
        check("orphan.err_set", 64'(bus.orphan_err), 64'd1);
        drive_resp(1'b0, 0, 1'b0);
        next_cycle();
        next_cycle();
        check("orphan.err_sticky", 64'(bus.orphan_err), 64'd1);

        // ---------------- mid-operation reset ----------------
        bus.req_valid = 2'b01;
        for (int s = 0; s < 3; s++) next_cycle();
        bus.req_valid = 2'b00;
        settle();
        check("midrst.inflight_before", 64'(bus.inflight), 64'd3);
        do_reset("midrst");
        bus.req_valid     = 2'b11;
        bus.mem_req_ready = 1'b1;
        settle();
        check("midrst.first_grant",  64'(bus.req_ready), 64'd1);
        next_cycle();
        check("midrst.second_grant", 64'(bus.req_ready), 64'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/modelbuf_read_arbiter.md
Name: modelbuf_read_arbiter

Overview:
- Shares the single model-buffer read port between NUM_REQ scene-reader lanes, so several model instances can be transformed in parallel.
- Grants requests round-robin and forwards the winner's modelbuf_read_t to the model buffer.
- Records the requester ID of every issued read in an in-order tag FIFO, then routes each returned triangle_t and triangle_meta_t back to the lane that asked for it.
- Sits between the SceneReader instances and the model buffer.

Parameters:
- NUM_REQ, 2, number of requester lanes (1..8).
- MAX_INFLIGHT, 4, depth of the tag FIFO, i.e. the maximum number of issued reads still awaiting a response (power of two, ≥2).
- RIDX_W, $clog2(NUM_REQ) (min 1), width of a requester ID.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-lane read request valid.
- req_ready  out  NUM_REQ  per-lane read request accepted.
- req_data  in  NUM_REQ x modelbuf_read_t  per-lane model_index/triangle_index.
- mem_req_valid  out  1  read request to the model buffer.
- mem_req_ready  in  1  model buffer accepts the request.
- mem_req_data  out  modelbuf_read_t  granted request.
- mem_resp_valid  in  1  model buffer response valid.
- mem_resp_ready  out  1  arbiter accepts the response.
- mem_resp_data  in  triangle_t  returned triangle.
- mem_resp_metadata  in  triangle_meta_t  returned metadata (last).
- resp_valid  out  NUM_REQ  per-lane response valid.
- resp_ready  in  NUM_REQ  per-lane response ready.
- resp_data  out  triangle_t  broadcast to all lanes; qualified by resp_valid.
- resp_metadata  out  triangle_meta_t  broadcast; qualified by resp_valid.
- inflight  out  $clog2(MAX_INFLIGHT)+1  number of outstanding reads.
- orphan_err  out  1  sticky error: a response arrived while no read was outstanding.

Behaviour:
- Registered state:
  - rr_ptr (RIDX_W) resets to 0.
  - Tag FIFO (wr_ptr, rd_ptr, count) resets to empty.
  - orphan_err resets to 0.
- All other outputs are combinational from state and inputs. With no inputs asserted after reset, all outputs are 0 and inflight=0.
- Grant: the first lane i with req_valid[i], scanning cyclically from rr_ptr upward. Lanes ≥NUM_REQ are never granted.
- full = (count==MAX_INFLIGHT). The FIFO never accepts a push while full, even if a pop occurs in the same cycle.
- Request path:
  - mem_req_valid = |req_valid && !full.
  - mem_req_data = req_data[grant].
  - req_ready[i] = (i==grant) && |req_valid && mem_req_ready && !full.
  - mem_req_valid must not depend on mem_req_ready.
- On an issue handshake (mem_req_valid && mem_req_ready): push grant into the tag FIFO, and set rr_ptr to grant+1, wrapping NUM_REQ-1 to 0. Otherwise rr_ptr holds.
- Zero-cycle latency from req to mem_req. There are no request bubbles while the FIFO is not full.
- Response path, with head = tag FIFO head:
  - resp_valid[i] = mem_resp_valid && count!=0 && head==i.
  - mem_resp_ready = count!=0 && resp_ready[head].
  - Pop on mem_resp_valid && mem_resp_ready.
  - resp_data and resp_metadata pass mem_resp_data and mem_resp_metadata through unchanged.
- Responses are delivered strictly in issue order. A lane that is not ready stalls all responses (head-of-line blocking by design).
- Simultaneous push and pop when not full: count is unchanged and both pointers advance.
- Pointer wrap: wr_ptr and rd_ptr wrap modulo MAX_INFLIGHT.
- inflight = count.
- Orphan response (mem_resp_valid && count==0): mem_resp_ready stays 0, no resp_valid is raised, and orphan_err is set to 1 on the next edge. orphan_err is cleared only by reset.
- Reset mid-operation: the FIFO is emptied, rr_ptr=0 and orphan_err=0 immediately (asynchronously). Outstanding responses are discarded; any that arrive later count as orphans. Upstream lanes are reset together with the arbiter.
- metadata.last has no effect on arbitration. Lanes may interleave per triangle; ordering within each lane is preserved.

Test Plan:
- Single lane: lane0 issues triangle_index 0,1,2 of model 3 with mem_req_ready=1, and the buffer returns three triangles one cycle later each, the third with last=1. Required: mem_req_data matches 3/0, 3/1, 3/2; only resp_valid[0] ever rises; data and last are forwarded; inflight peaks at ≤2 and ends at 0.
- Round-robin fairness: lanes 0 and 1 both continuously valid, mem_req_ready=1, responses ready. Required: grants alternate 0,1,0,1 starting from lane 0 after reset; over 8 issues each lane gets exactly 4.
- Full FIFO: MAX_INFLIGHT=4, both lanes valid, no responses for 6 cycles. Required: exactly 4 issues, then mem_req_valid=0 and req_ready=0 with inflight=4. One response pops and frees one slot; the next issue occurs on the following cycle, not the same one.
- Routing and back-pressure: issue order 1,0,1. Required: responses go to resp_valid[1], [0], [1] in that order. Holding resp_ready[0]=0 for 3 cycles keeps mem_resp_ready=0 and blocks the third response until it is released.
- Orphan: mem_resp_valid=1 with inflight=0. Required: mem_resp_ready=0, all resp_valid=0, orphan_err=1 from the next cycle and sticky until rstn=0.
- Mid-operation reset: inflight=3, assert rstn=0 for 1 cycle. Required: inflight=0, rr_ptr=0 and all outputs 0 during reset; after release, the first grant goes to lane 0 when both lanes request.
